mshr_ctrl: RTL and testbench
============================

# mshr_ctrl

Memory-side controller behind the mem stage's mmio port. It answers every request one cycle later with exactly one of hit_ack, miss_store, passive_stall or load_done_stall. Fast-region accesses are served from an internal scratchpad. Slow-region loads and stores are queued in a 4-entry in-order MSHR and issued one at a time on an external request/grant bus; returned load data is injected back to the mem stage.

## Interface

Parameters:
- NUM_MSHR, 4: queue depth; must match the mem stage's MSHR_REG.
- SPAD_WORDS, 1024: scratchpad depth in 32-bit words.
- FAST_BASE, 16'h0000: addr[31:16] value that selects the scratchpad.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock
- rst  in  1  async active-high reset
- mmio_req  in  1  request valid from mem stage
- mmio_lw  in  1  1 load, 0 store
- mmio_addr  in  32  byte address, word aligned
- mmio_data_write  in  32  store data
- mmio_regD  in  5  load destination register
- mmio_data_read  out  32  hit data or returned miss data
- hit_ack  out  1  request completed
- miss_store  out  1  load queued in MSHR
- passive_stall  out  1  request refused, mem stage re-requests
- load_done_stall  out  1  queued load returned this cycle
- regD_done  out  5  destination register of the returned load
- bus_req  out  1  slow-bus request, held until bus_gnt
- bus_we  out  1  slow-bus write enable
- bus_addr  out  32  slow-bus address
- bus_wdata  out  32  slow-bus write data
- bus_gnt  in  1  bus accepted the request
- bus_rvalid  in  1  read data valid, at least 1 cycle after gnt
- bus_rdata  in  32  read data

## Operation

Response outputs:
- All response outputs are registered. A request sampled at edge N is answered in cycle N+1.
- At most one of hit_ack, miss_store, passive_stall and load_done_stall is high in any cycle.
- Every response pulses for exactly one cycle.

Request classification at N, applied only if no return is pending (see priority below):
- Fast region (addr[31:16]==FAST_BASE), load: scratchpad read at word index addr[11:2]. Response is hit_ack with mmio_data_read = word.
- Fast region, store: write at edge N. Response is hit_ack.
- Slow region with queue not full: push {we, addr, wdata, regD}. Response is miss_store for a load, hit_ack for a store.
- Slow region with queue full: no push. Response is passive_stall.

Response priority:
- If a return-buffer entry is valid at edge N, the cycle N+1 response is load_done_stall, with regD_done and mmio_data_read taken from the buffer.
- Any request at N is then dropped; the mem stage re-issues it.
- Return data is never lost.

Bus scheduler states:
- IDLE: queue non-empty moves to ISSUE.
- ISSUE: bus_req=1, with we, addr and wdata from the queue head, held stable. On bus_gnt:
  - Store: pop and go to IDLE.
  - Load: go to WAIT.
- WAIT: on bus_rvalid, capture {regD, bus_rdata} into the return buffer, pop the head and go to RETURN.
- RETURN: hold until the buffer has been presented (next cycle), then go to IDLE. Only one bus transaction is ever outstanding.

Ordering:
- Queue order is strict FIFO; loads return in issue order.
- A push and a pop in the same cycle are legal when the queue is full.

## Timing

- Reset: all outputs are 0, the queue is empty, the return buffer is invalid, and the scheduler is in IDLE. Scratchpad contents are undefined.
- Reset mid-transaction: the outstanding bus transaction is abandoned and bus_req drops asynchronously.
- Fast hit latency: 1 cycle.
- Miss latency: minimum 4 cycles from request to load_done_stall (push at N, ISSUE at N+1, gnt at N+1, rvalid at N+2, load_done_stall at N+4).
- Queue full is decided from the occupancy at edge N, before that cycle's pop.
- Counters: read pointer, write pointer and count, modulo NUM_MSHR. The count width holds 0 to NUM_MSHR.

## Structure

- mem_pkg holds mshr_entry_t {we, addr, wdata, regD}, the sched_state_t enum, the FAST_BASE default, and the NUM_MSHR default shared with the mem stage.
- Sub-module mshr_fifo is a circular queue of mshr_entry_t with push, pop, full, empty and head ports.
- The scratchpad is an inferred array inside mshr_ctrl.

## Test plan

- Fast store 0x0000_0010 = 0xCAFE_F00D, then fast load from the same address with regD=5 -> hit_ack both cycles; load returns 0xCAFE_F00D.
- Slow load 0x8000_0000 with regD=7, bus gnt immediate, rdata 0x1234_5678 after 1 cycle -> miss_store at N+1; load_done_stall with regD_done=7 and 0x1234_5678 at N+4.
- Five back-to-back slow loads, bus_gnt held low -> four miss_store, then passive_stall; the re-request gets miss_store once the first entry retires.
- Return pending while a fast load request arrives -> load_done_stall only; the fast load re-issued next cycle gets hit_ack.
- Slow store, then slow load to the same address -> the bus sees the write before the read (FIFO order); the store response is hit_ack.
- rst asserted during WAIT -> bus_req=0, queue empty, and no load_done_stall after reset release.

Source files
------------

// File: rtl/mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : mem_pkg                                                      |
// | Description : Shared types and defaults for the mem stage and mshr_ctrl.  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package mem_pkg;

    localparam int          c_NUM_MSHR  = 4;
    localparam logic [15:0] c_FAST_BASE = 16'h0000;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  regD;
    } mshr_entry_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_WAIT   = 2'd2,
        S_RETURN = 2'd3
    } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/mshr_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface   : mshr_ctrl_if                                                 |
// | Description : mmio request/response port plus the slow request/grant bus. |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
interface mshr_ctrl_if;

    logic        mmio_req;
    logic        mmio_lw;
    logic [31:0] mmio_addr;
    logic [31:0] mmio_data_write;
    logic [4:0]  mmio_regD;
    logic [31:0] mmio_data_read;
    logic        hit_ack;
    logic        miss_store;
    logic        passive_stall;
    logic        load_done_stall;
    logic [4:0]  regD_done;

    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    // slave is the controller; master is the mem stage plus the slow bus.
    modport slave (
        input  mmio_req, mmio_lw, mmio_addr, mmio_data_write, mmio_regD,
        output mmio_data_read, hit_ack, miss_store, passive_stall,
        output load_done_stall, regD_done,
        output bus_req, bus_we, bus_addr, bus_wdata,
        input  bus_gnt, bus_rvalid, bus_rdata
    );

    modport master (
        output mmio_req, mmio_lw, mmio_addr, mmio_data_write, mmio_regD,
        input  mmio_data_read, hit_ack, miss_store, passive_stall,
        input  load_done_stall, regD_done,
        input  bus_req, bus_we, bus_addr, bus_wdata,
        output bus_gnt, bus_rvalid, bus_rdata
    );

endinterface
`default_nettype wire

// File: rtl/mshr_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mshr_fifo                                                    |
// | Description : Circular in-order queue of MSHR entries.                     |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module mshr_fifo
    import mem_pkg::*;
#(
    parameter int DEPTH = c_NUM_MSHR
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        push,
    input  mshr_entry_t      push_entry,
    input  wire logic        pop,
    output mshr_entry_t      head,
    output logic             full,
    output logic             empty
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    mshr_entry_t          r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;
    logic                 w_do_push;
    logic                 w_do_pop;

    function automatic logic [c_PTR_W-1:0] next_ptr(input logic [c_PTR_W-1:0] ptr);
        return (ptr == c_PTR_W'(DEPTH - 1)) ? '0 : ptr + c_PTR_W'(1);
    endfunction

    assign full      = (r_count == c_CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign head      = r_mem[r_rd_ptr];
    assign w_do_pop  = pop && !empty;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/mshr_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mshr_ctrl                                                    |
// | Description : Scratchpad hits plus in-order MSHR queue for slow accesses. |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module mshr_ctrl
    import mem_pkg::*;
#(
    parameter int          NUM_MSHR   = c_NUM_MSHR,
    parameter int          SPAD_WORDS = 1024,
    parameter logic [15:0] FAST_BASE  = c_FAST_BASE
) (
    input  wire logic  clk,
    input  wire logic  rst,
    mshr_ctrl_if.slave io
);

    localparam int c_IDX_W = $clog2(SPAD_WORDS);

    logic [31:0]        r_spad [SPAD_WORDS];
    logic [c_IDX_W-1:0] w_idx;
    logic               w_fast;
    logic               w_accept;
    logic               w_push;
    logic               w_pop;
    logic               w_spad_we;
    logic               w_full;
    logic               w_empty;
    mshr_entry_t        w_push_entry;
    mshr_entry_t        w_head;
    mshr_entry_t        w_issue_entry;

    sched_state_t       r_state;
    logic               r_bus_req;
    logic               r_bus_we;
    logic [31:0]        r_bus_addr;
    logic [31:0]        r_bus_wdata;
    logic               r_ret_valid;
    logic [31:0]        r_ret_data;
    logic [4:0]         r_ret_regD;

    logic               r_hit_ack;
    logic               r_miss_store;
    logic               r_passive_stall;
    logic               r_load_done_stall;
    logic [31:0]        r_data_read;
    logic [4:0]         r_regD_done;

    assign w_fast    = (io.mmio_addr[31:16] == FAST_BASE);
    assign w_idx     = io.mmio_addr[2 +: c_IDX_W];
    // A pending return owns the response slot; the request is dropped and re-issued.
    assign w_accept  = io.mmio_req && !r_ret_valid;
    assign w_push    = w_accept && !w_fast && !w_full;
    assign w_spad_we = w_accept && w_fast && !io.mmio_lw;
    assign w_pop     = ((r_state == S_ISSUE) && io.bus_gnt && w_head.we) ||
                       ((r_state == S_WAIT) && io.bus_rvalid);

    assign w_push_entry.we    = !io.mmio_lw;
    assign w_push_entry.addr  = io.mmio_addr;
    assign w_push_entry.wdata = io.mmio_data_write;
    assign w_push_entry.regD  = io.mmio_regD;

    // Lets an entry pushed this cycle go straight onto the bus.
    assign w_issue_entry = w_empty ? w_push_entry : w_head;

    mshr_fifo #(
        .DEPTH (NUM_MSHR)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (w_push),
        .push_entry (w_push_entry),
        .pop        (w_pop),
        .head       (w_head),
        .full       (w_full),
        .empty      (w_empty)
    );

    always_ff @(posedge clk) begin
        if (w_spad_we) begin
            r_spad[w_idx] <= io.mmio_data_write;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hit_ack         <= 1'b0;
            r_miss_store      <= 1'b0;
            r_passive_stall   <= 1'b0;
            r_load_done_stall <= 1'b0;
            r_data_read       <= '0;
            r_regD_done       <= '0;
        end else begin
            r_hit_ack         <= 1'b0;
            r_miss_store      <= 1'b0;
            r_passive_stall   <= 1'b0;
            r_load_done_stall <= 1'b0;
            if (r_ret_valid) begin
                r_load_done_stall <= 1'b1;
                r_data_read       <= r_ret_data;
                r_regD_done       <= r_ret_regD;
            end else if (io.mmio_req) begin
                if (w_fast) begin
                    r_hit_ack <= 1'b1;
                    if (io.mmio_lw) begin
                        r_data_read <= r_spad[w_idx];
                    end
                end else if (w_full) begin
                    r_passive_stall <= 1'b1;
                end else if (io.mmio_lw) begin
                    r_miss_store <= 1'b1;
                end else begin
                    r_hit_ack <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_ret_valid <= 1'b0;
            r_ret_data  <= '0;
            r_ret_regD  <= '0;
        end else begin
            if (r_ret_valid) begin
                r_ret_valid <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (!w_empty || w_push) begin
                        r_state     <= S_ISSUE;
                        r_bus_req   <= 1'b1;
                        r_bus_we    <= w_issue_entry.we;
                        r_bus_addr  <= w_issue_entry.addr;
                        r_bus_wdata <= w_issue_entry.wdata;
                    end
                end
                S_ISSUE: begin
                    if (io.bus_gnt) begin
                        r_bus_req <= 1'b0;
                        r_state   <= w_head.we ? S_IDLE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (io.bus_rvalid) begin
                        r_ret_valid <= 1'b1;
                        r_ret_data  <= io.bus_rdata;
                        r_ret_regD  <= w_head.regD;
                        r_state     <= S_RETURN;
                    end
                end
                S_RETURN: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign io.hit_ack         = r_hit_ack;
    assign io.miss_store      = r_miss_store;
    assign io.passive_stall   = r_passive_stall;
    assign io.load_done_stall = r_load_done_stall;
    assign io.mmio_data_read  = r_data_read;
    assign io.regD_done       = r_regD_done;
    assign io.bus_req         = r_bus_req;
    assign io.bus_we          = r_bus_we;
    assign io.bus_addr        = r_bus_addr;
    assign io.bus_wdata       = r_bus_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mshr_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mshr_ctrl                                                 |
// | Description : Directed vector table plus multi-cycle sequences.            |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_mshr_ctrl;

    localparam logic [3:0]  R_NONE = 4'b0000;
    localparam logic [3:0]  R_HIT  = 4'b1000;
    localparam logic [3:0]  R_MISS = 4'b0100;
    localparam logic [3:0]  R_PST  = 4'b0010;
    localparam logic [3:0]  R_LD   = 4'b0001;
    localparam logic [31:0] c_RMASK = 32'h9234_5678;

    typedef struct {
        logic        req;
        logic        lw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  regd;
        logic [3:0]  exp_resp;
        logic        chk_data;
        logic [31:0] exp_data;
    } vec_t;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    bit          gnt_en;
    int          rlat;
    bit          rd_pending;
    int          rd_cnt;
    logic [31:0] rd_addr;
    bit          gnt_is_read;
    logic [31:0] gnt_addr;
    bit          log_we[$];
    logic [31:0] log_addr[$];
    logic [31:0] log_wdata[$];

    mshr_ctrl_if io ();

    mshr_ctrl #(
        .NUM_MSHR   (4),
        .SPAD_WORDS (1024),
        .FAST_BASE  (16'h0000)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slow-bus responder: grant while enabled, read data rlat cycles after the grant edge.
    always @(negedge clk) begin
        if (rst) begin
            rd_pending    = 1'b0;
            gnt_is_read   = 1'b0;
            io.bus_gnt    = 1'b0;
            io.bus_rvalid = 1'b0;
            io.bus_rdata  = '0;
        end else begin
            if (io.bus_gnt && gnt_is_read) begin
                rd_pending = 1'b1;
                rd_cnt     = rlat;
                rd_addr    = gnt_addr;
            end
            io.bus_rvalid = 1'b0;
            if (rd_pending) begin
                if (rd_cnt == 0) begin
                    io.bus_rvalid = 1'b1;
                    io.bus_rdata  = rd_addr ^ c_RMASK;
                    rd_pending    = 1'b0;
                end else begin
                    rd_cnt--;
                end
            end
            io.bus_gnt = gnt_en && io.bus_req && !rd_pending;
            if (io.bus_gnt) begin
                log_we.push_back(io.bus_we);
                log_addr.push_back(io.bus_addr);
                log_wdata.push_back(io.bus_wdata);
                gnt_is_read = !io.bus_we;
                gnt_addr    = io.bus_addr;
            end
        end
    end

    function automatic logic [3:0] resp();
        return {io.hit_ack, io.miss_store, io.passive_stall, io.load_done_stall};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic cyc(input logic req, input logic lw, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [4:0] regd);
        io.mmio_req        = req;
        io.mmio_lw         = lw;
        io.mmio_addr       = addr;
        io.mmio_data_write = wdata;
        io.mmio_regD       = regd;
        @(posedge clk);
        #2;
    endtask

    task automatic wait_ldone(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            cyc(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
            if (io.load_done_stall) seen = 1'b1;
        end
    endtask

    vec_t vecs [11];

    initial begin
        bit seen;
        int n_ld;
        int n_rq;

        n_pass = 0;
        n_total = 0;
        gnt_en = 1'b1;
        rlat = 0;
        rst = 1'b1;
        io.mmio_req = 1'b0;
        io.mmio_lw = 1'b0;
        io.mmio_addr = '0;
        io.mmio_data_write = '0;
        io.mmio_regD = '0;

        vecs[0]  = '{1'b1, 1'b0, 32'h0000_0010, 32'hCAFE_F00D, 5'd0, R_HIT,  1'b0, 32'h0};
        vecs[1]  = '{1'b1, 1'b1, 32'h0000_0010, 32'h0,         5'd5, R_HIT,  1'b1, 32'hCAFE_F00D};
        vecs[2]  = '{1'b1, 1'b0, 32'h0000_0014, 32'h1111_2222, 5'd0, R_HIT,  1'b0, 32'h0};
        vecs[3]  = '{1'b1, 1'b0, 32'h0000_0FFC, 32'hDEAD_BEEF, 5'd0, R_HIT,  1'b0, 32'h0};
        vecs[4]  = '{1'b1, 1'b1, 32'h0000_0FFC, 32'h0,         5'd1, R_HIT,  1'b1, 32'hDEAD_BEEF};
        vecs[5]  = '{1'b1, 1'b1, 32'h0000_0014, 32'h0,         5'd2, R_HIT,  1'b1, 32'h1111_2222};
        vecs[6]  = '{1'b1, 1'b1, 32'h0000_1010, 32'h0,         5'd3, R_HIT,  1'b1, 32'hCAFE_F00D};
        vecs[7]  = '{1'b0, 1'b1, 32'h8000_0000, 32'h0,         5'd0, R_NONE, 1'b0, 32'h0};
        vecs[8]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0BAD_F00D, 5'd0, R_HIT,  1'b0, 32'h0};
        vecs[9]  = '{1'b1, 1'b1, 32'h0000_0000, 32'h0,         5'd4, R_HIT,  1'b1, 32'h0BAD_F00D};
        vecs[10] = '{1'b1, 1'b1, 32'h0000_0FFC, 32'h0,         5'd6, R_HIT,  1'b1, 32'hDEAD_BEEF};

        repeat (3) @(posedge clk);
        #2;
        chk("reset resp", 32'(resp()), 32'(R_NONE));
        chk("reset bus_req", 32'(io.bus_req), 32'd0);
        chk("reset data_read", io.mmio_data_read, 32'h0);
        chk("reset regD_done", 32'(io.regD_done), 32'd0);
        chk("reset bus_addr", io.bus_addr, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            cyc(vecs[i].req, vecs[i].lw, vecs[i].addr, vecs[i].wdata, vecs[i].regd);
            chk($sformatf("vec%0d resp", i), 32'(resp()), 32'(vecs[i].exp_resp));
            if (vecs[i].chk_data) begin
                chk($sformatf("vec%0d data", i), io.mmio_data_read, vecs[i].exp_data);
            end
        end

        // Minimum-latency slow load.
        cyc(1'b1, 1'b1, 32'h8000_0000, 32'h0, 5'd7);
        chk("slow ld resp N+1", 32'(resp()), 32'(R_MISS));
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        chk("slow ld N+2", 32'(resp()), 32'(R_NONE));
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        chk("slow ld N+3", 32'(resp()), 32'(R_NONE));
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        chk("slow ld N+4 resp", 32'(resp()), 32'(R_LD));
        chk("slow ld regD_done", 32'(io.regD_done), 32'd7);
        chk("slow ld data", io.mmio_data_read, 32'h1234_5678);

        // Return pending while a fast load arrives.
        cyc(1'b1, 1'b1, 32'h8000_0040, 32'h0, 5'd9);
        chk("prio miss", 32'(resp()), 32'(R_MISS));
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        cyc(1'b1, 1'b1, 32'h0000_0010, 32'h0, 5'd5);
        chk("prio ldone only", 32'(resp()), 32'(R_LD));
        chk("prio regD_done", 32'(io.regD_done), 32'd9);
        chk("prio data", io.mmio_data_read, 32'h8000_0040 ^ c_RMASK);
        cyc(1'b1, 1'b1, 32'h0000_0010, 32'h0, 5'd5);
        chk("prio reissue hit", 32'(resp()), 32'(R_HIT));
        chk("prio reissue data", io.mmio_data_read, 32'hCAFE_F00D);

        // Queue fill with the bus stalled.
        gnt_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b1, 32'h8000_1000 + 32'(4 * i), 32'h0, 5'(i + 1));
            chk($sformatf("fill%0d miss", i), 32'(resp()), 32'(R_MISS));
        end
        cyc(1'b1, 1'b1, 32'h8000_1010, 32'h0, 5'd5);
        chk("fill full pstall", 32'(resp()), 32'(R_PST));
        gnt_en = 1'b1;
        cyc(1'b1, 1'b1, 32'h8000_1010, 32'h0, 5'd5);
        chk("fill gnt pstall", 32'(resp()), 32'(R_PST));
        cyc(1'b1, 1'b1, 32'h8000_1010, 32'h0, 5'd5);
        chk("fill pop-edge pstall", 32'(resp()), 32'(R_PST));
        cyc(1'b1, 1'b1, 32'h8000_1010, 32'h0, 5'd5);
        chk("fill ret ldone", 32'(resp()), 32'(R_LD));
        chk("fill ret regD", 32'(io.regD_done), 32'd1);
        chk("fill ret data", io.mmio_data_read, 32'h8000_1000 ^ c_RMASK);
        cyc(1'b1, 1'b1, 32'h8000_1010, 32'h0, 5'd5);
        chk("fill reissue miss", 32'(resp()), 32'(R_MISS));
        for (int k = 1; k < 5; k++) begin
            wait_ldone(20, seen);
            chk($sformatf("drain%0d seen", k), 32'(seen), 32'd1);
            chk($sformatf("drain%0d regD", k), 32'(io.regD_done), 32'(k + 1));
            chk($sformatf("drain%0d data", k), io.mmio_data_read,
                (32'h8000_1000 + 32'(4 * k)) ^ c_RMASK);
        end

        // Slow store then slow load to the same address.
        log_we.delete();
        log_addr.delete();
        log_wdata.delete();
        cyc(1'b1, 1'b0, 32'h8000_0100, 32'hA5A5_5A5A, 5'd0);
        chk("st-ld store resp", 32'(resp()), 32'(R_HIT));
        cyc(1'b1, 1'b1, 32'h8000_0100, 32'h0, 5'd12);
        chk("st-ld load resp", 32'(resp()), 32'(R_MISS));
        wait_ldone(20, seen);
        chk("st-ld ldone seen", 32'(seen), 32'd1);
        chk("st-ld regD", 32'(io.regD_done), 32'd12);
        chk("st-ld bus txns", 32'(log_we.size()), 32'd2);
        if (log_we.size() == 2) begin
            chk("st-ld first is write", 32'(log_we[0]), 32'd1);
            chk("st-ld write addr", log_addr[0], 32'h8000_0100);
            chk("st-ld write data", log_wdata[0], 32'hA5A5_5A5A);
            chk("st-ld second is read", 32'(log_we[1]), 32'd0);
            chk("st-ld read addr", log_addr[1], 32'h8000_0100);
        end

        // Reset while a load waits for read data.
        rlat = 6;
        cyc(1'b1, 1'b1, 32'h8000_0200, 32'h0, 5'd3);
        chk("rst-wait miss", 32'(resp()), 32'(R_MISS));
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        rst = 1'b1;
        #1;
        chk("rst-wait bus_req", 32'(io.bus_req), 32'd0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        rlat = 0;
        n_ld = 0;
        n_rq = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
            if (io.load_done_stall) n_ld++;
            if (io.bus_req) n_rq++;
        end
        chk("rst-wait no ldone", 32'(n_ld), 32'd0);
        chk("rst-wait queue empty", 32'(n_rq), 32'd0);
        cyc(1'b1, 1'b1, 32'h0000_0010, 32'h0, 5'd1);
        chk("post-rst fast hit", 32'(resp()), 32'(R_HIT));

        // Reset during ISSUE drops bus_req without a clock edge.
        gnt_en = 1'b0;
        cyc(1'b1, 1'b1, 32'h8000_0300, 32'h0, 5'd4);
        chk("rst-issue bus_req before", 32'(io.bus_req), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst-issue bus_req async", 32'(io.bus_req), 32'd0);
        chk("rst-issue resp async", 32'(resp()), 32'(R_NONE));
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
